// File: rtl/regshift_pipe_if.sv
// Handshake bundle between register read and the operand-2 shifter pipeline.
// master drives operations in and accepts results; slave is the shifter.
interface regshift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] rs;
    logic             c_in;
    logic             v_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, rm, rs, c_in, v_in, tag_in, out_ready,
        input  in_ready, out_valid, rd, flags, tag_out
    );

    modport slave (
        input  in_valid, op, rm, rs, c_in, v_in, tag_in, out_ready,
        output in_ready, out_valid, rd, flags, tag_out
    );
endinterface

// File: rtl/regshift_pipe.sv
// Pipelined register-amount shifter (LSL/LSR/ASR/ROR/RRX) with NZCV flags.
// The full shift is resolved at accept; the remaining stages are delay
// registers that move in lock-step, so latency is STAGES cycles unstalled.
module regshift_pipe #(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    regshift_pipe_if.slave  bus
);

    localparam int               SH_W  = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [AMT_W-1:0] amt;
    logic [SH_W-1:0]  sh;
    logic             amt_zero;
    logic             amt_lt_w;
    logic             amt_eq_w;

    assign amt      = bus.rs[AMT_W-1:0];
    assign sh       = amt[SH_W-1:0];
    assign amt_zero = (amt == '0);
    assign amt_lt_w = (amt < W_AMT);
    assign amt_eq_w = (amt == W_AMT);

    // Only the low AMT_W bits of rs select the amount.
    generate
        if (AMT_W < WIDTH) begin : g_rs_hi
            logic unused_rs_hi;
            assign unused_rs_hi = ^bus.rs[WIDTH-1:AMT_W];
        end
    endgenerate

    // Extended shifts: the extra bit catches the last bit shifted out,
    // which is the carry for in-range LSL/LSR/ASR amounts.
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH-1:0] asr_res;
    logic [WIDTH-1:0] rot_res;

    assign lsl_ext = {1'b0, bus.rm} << sh;
    assign lsr_ext = {bus.rm, 1'b0} >> sh;
    assign asr_res = $unsigned($signed(bus.rm) >>> sh);

    // True rotate: result bit gi takes rm[(gi + amt) mod WIDTH]; the SH_W-bit
    // sum wraps naturally because WIDTH is a power of two.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rot_res[gi] = bus.rm[SH_W'(gi) + sh];
        end
    endgenerate

    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic [3:0]       flags_next;

    // Result and shifter carry selection; zero amount leaves rm and c_in alone.
    always_comb begin
        res_next   = bus.rm;
        carry_next = bus.c_in;
        case (bus.op)
            3'd0: if (!amt_zero) begin
                if (amt_lt_w) begin
                    res_next   = lsl_ext[WIDTH-1:0];
                    carry_next = lsl_ext[WIDTH];
                end else if (amt_eq_w) begin
                    res_next   = '0;
                    carry_next = bus.rm[0];
                end else begin
                    res_next   = '0;
                    carry_next = 1'b0;
                end
            end
            3'd1: if (!amt_zero) begin
                if (amt_lt_w) begin
                    res_next   = lsr_ext[WIDTH:1];
                    carry_next = lsr_ext[0];
                end else if (amt_eq_w) begin
                    res_next   = '0;
                    carry_next = bus.rm[WIDTH-1];
                end else begin
                    res_next   = '0;
                    carry_next = 1'b0;
                end
            end
            3'd2: if (!amt_zero) begin
                if (amt_lt_w) begin
                    res_next   = asr_res;
                    carry_next = lsr_ext[0];
                end else begin
                    res_next   = {WIDTH{bus.rm[WIDTH-1]}};
                    carry_next = bus.rm[WIDTH-1];
                end
            end
            // After rotating, the last bit rotated out sits in the MSB; this
            // also covers the multiple-of-WIDTH case (C = rm[WIDTH-1]).
            3'd3: if (!amt_zero) begin
                res_next   = rot_res;
                carry_next = rot_res[WIDTH-1];
            end
            3'd4: begin
                res_next   = {bus.c_in, bus.rm[WIDTH-1:1]};
                carry_next = bus.rm[0];
            end
            default: ;
        endcase
    end

    assign flags_next = {res_next[WIDTH-1], (res_next == '0), carry_next, bus.v_in};

    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] rd_reg    [STAGES];
    logic [3:0]       flags_reg [STAGES];
    logic [TAG_W-1:0] tag_reg   [STAGES];
    logic             advance;

    assign advance      = ~valid_reg[STAGES-1] | bus.out_ready;
    assign bus.in_ready = advance;

    // Lock-step pipeline: every stage moves together on advance; payloads
    // update only when a valid op arrives so the output holds its last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_reg[i] <= 1'b0;
                rd_reg[i]    <= '0;
                flags_reg[i] <= '0;
                tag_reg[i]   <= '0;
            end
        end else if (advance) begin
            valid_reg[0] <= bus.in_valid;
            if (bus.in_valid) begin
                rd_reg[0]    <= res_next;
                flags_reg[0] <= flags_next;
                tag_reg[0]   <= bus.tag_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                if (valid_reg[i-1]) begin
                    rd_reg[i]    <= rd_reg[i-1];
                    flags_reg[i] <= flags_reg[i-1];
                    tag_reg[i]   <= tag_reg[i-1];
                end
            end
        end
    end

    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.rd        = rd_reg[STAGES-1];
    assign bus.flags     = flags_reg[STAGES-1];
    assign bus.tag_out   = tag_reg[STAGES-1];

endmodule
